jt49_eg_timer: RTL and testbench



---
 rtl/jt49_pkg.sv | 16 +
 rtl/jt49_eg_timer.sv | 96 +++++++++
 tb/tb_jt49_eg_timer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/jt49_pkg.sv
// Shared register map and shape-register bit positions for the jt49 envelope
// path. Used by jt49_eg_timer and jt49_eg.
package jt49_pkg;

  // Envelope register addresses
  localparam logic [3:0] JT49_R_EPFINE   = 4'd11;
  localparam logic [3:0] JT49_R_EPCOARSE = 4'd12;
  localparam logic [3:0] JT49_R_ESHAPE   = 4'd13;

  // Bit positions inside ctrl = {CONT, ATT, ALT, HOLD}
  localparam int JT49_CTRL_CONT = 3;
  localparam int JT49_CTRL_ATT  = 2;
  localparam int JT49_CTRL_ALT  = 1;
  localparam int JT49_CTRL_HOLD = 0;

endpackage

// File: rtl/jt49_eg_timer.sv
// Envelope timing front-end: R11/R12 period, R13 shape, and the envelope
// period counter that produces step/null_period/restart for jt49_eg.
//
// Build option JT49_EG_YM_STEP_EN:
//   defined     -> step is a pulse held from an expiry cen until the next cen
//                  (YM2149 rate, one rising edge per expiry)
//   not defined -> step toggles on each expiry (AY-3-8910 half rate)
module jt49_eg_timer
  import jt49_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  (* direct_enable *) input  logic  cen,
  input  logic                      wr,
  input  logic [3:0]                addr,
  input  logic [7:0]                din,
  output logic [3:0]                ctrl,
  output logic                      step,
  output logic                      null_period,
  output logic                      restart,
  output logic [15:0]               period
);

  logic [15:0] cnt;
  logic        wr_fine;
  logic        wr_coarse;
  logic        wr_shape;
  logic        period_zero;
  logic        at_limit;
  logic        expire;

  assign wr_fine     = wr && (addr == JT49_R_EPFINE);
  assign wr_coarse   = wr && (addr == JT49_R_EPCOARSE);
  assign wr_shape    = wr && (addr == JT49_R_ESHAPE);
  assign period_zero = (period == 16'd0);

  // ">=" rather than "==" so a period shrunk below the running count expires
  // on the next cen instead of running on to 0xFFFF.
  always_comb begin
    at_limit = 1'b0;
    if (!period_zero) at_limit = (cnt >= (period - 16'd1));
    expire = cen && at_limit;
  end

  // CPU register file: period halves and shape, writes are not cen-qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= 16'd0;
      ctrl   <= 4'b0000;
    end else begin
      if (wr_fine)   period[7:0]  <= din;
      if (wr_coarse) period[15:8] <= din;
      if (wr_shape)  ctrl         <= din[3:0];
    end
  end

  // One restart pulse per shape write; back-to-back writes stretch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) restart <= 1'b0;
    else        restart <= wr_shape;
  end

  // Registered zero-period flag, lags the period register by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) null_period <= 1'b1;
    else        null_period <= period_zero;
  end

  // Period counter; a shape write restarts it and swallows a coincident expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (wr_shape) begin
      cnt <= 16'd0;
    end else if (cen) begin
      if (period_zero || expire) cnt <= 16'd0;
      else                       cnt <= cnt + 16'd1;
    end
  end

  // Step output, form selected at build time; restart forces it low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= 1'b0;
    end else if (wr_shape) begin
      step <= 1'b0;
    end else if (cen) begin
`ifdef JT49_EG_YM_STEP_EN
      step <= expire;
`else
      if (expire) step <= ~step;
`endif
    end
  end

endmodule

// File: tb/tb_jt49_eg_timer.sv
// Self-checking bench for jt49_eg_timer: per-cycle comparison against a
// behavioural model plus directed literal checks.
module tb_jt49_eg_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [7:0]  din = 8'd0;
  logic [3:0]  ctrl;
  logic        step;
  logic        null_period;
  logic        restart;
  logic [15:0] period;

  int n_checks = 0;
  int n_fail   = 0;
  int rises    = 0;
  logic prev_step = 1'b0;

  jt49_eg_timer dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .ctrl(ctrl), .step(step), .null_period(null_period), .restart(restart),
    .period(period)
  );

  always #5 clk = ~clk;

`ifdef JT49_EG_YM_STEP_EN
  localparam bit YM = 1'b1;
`else
  localparam bit YM = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  // Tracks how many cens have elapsed since the last boundary; the period-th
  // cen is an expiry.
  logic [15:0] m_period;
  logic [3:0]  m_ctrl;
  int          m_ticks;
  logic        m_step, m_restart, m_null;
  int          p;
  bit          hit, shape;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_period = 16'd0; m_ctrl = 4'd0; m_ticks = 0;
      m_step = 1'b0; m_restart = 1'b0; m_null = 1'b1;
    end else begin
      p     = int'(m_period);
      shape = wr && (addr == 4'd13);
      hit   = cen && (p != 0) && (m_ticks + 1 >= p);
      m_null    = (p == 0);
      m_restart = shape;
      if (shape) begin
        m_ctrl = din[3:0]; m_ticks = 0; m_step = 1'b0;
      end else if (cen) begin
        m_ticks = (p == 0 || hit) ? 0 : m_ticks + 1;
        if (YM) m_step = hit;
        else if (hit) m_step = ~m_step;
      end
      if (wr && addr == 4'd11) m_period[7:0]  = din;
      if (wr && addr == 4'd12) m_period[15:8] = din;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus step rising-edge counting.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("period", period, m_period);
      check("ctrl", {12'd0, ctrl}, {12'd0, m_ctrl});
      check("step", {15'd0, step}, {15'd0, m_step});
      check("restart", {15'd0, restart}, {15'd0, m_restart});
      check("null_period", {15'd0, null_period}, {15'd0, m_null});
      if (step && !prev_step) rises++;
      prev_step = step;
    end else begin
      prev_step = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic with_cen);
    @(negedge clk);
    wr = 1'b1; addr = a; din = d; cen = with_cen;
    @(negedge clk);
    wr = 1'b0; cen = 1'b0;
  endtask

  task automatic cens(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cen = 1'b1;
      @(negedge clk); cen = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  int r0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst period", period, 16'h0000);
    check("rst ctrl", {12'd0, ctrl}, 16'h0000);
    check("rst step", {15'd0, step}, 16'h0000);
    check("rst restart", {15'd0, restart}, 16'h0000);
    check("rst null", {15'd0, null_period}, 16'h0001);
    rst_n = 1'b1;
    @(negedge clk);

    // Period 3, cen every 4 clk, 12 cens
    do_write(4'd11, 8'd3, 1'b0);
    do_write(4'd12, 8'd0, 1'b0);
    check("period3 value", period, 16'h0003);
    r0 = rises;
    cens(12, 4);
    check("period3 rises", 16'(rises - r0), YM ? 16'd4 : 16'd2);

    // Shape write while step is high
    cens(3, 4);
    check("pre-shape step", {15'd0, step}, 16'd1);
    do_write(4'd13, 8'h0E, 1'b0);
    check("shape restart", {15'd0, restart}, 16'd1);
    check("shape ctrl", {12'd0, ctrl}, 16'h000E);
    check("shape step clr", {15'd0, step}, 16'd0);
    @(negedge clk);
    check("shape restart 1clk", {15'd0, restart}, 16'd0);
    cens(2, 4);
    check("post-shape step 2", {15'd0, step}, 16'd0);
    cens(1, 4);
    check("post-shape step 3", {15'd0, step}, 16'd1);

    // Shape write coincident with an expiry cen
    cens(2, 4);
    r0 = rises;
    do_write(4'd13, 8'h0A, 1'b1);
    check("coinc step", {15'd0, step}, 16'd0);
    check("coinc ctrl", {12'd0, ctrl}, 16'h000A);
    cens(2, 4);
    check("coinc step 2", {15'd0, step}, 16'd0);
    cens(1, 4);
    check("coinc step 3", {15'd0, step}, 16'd1);
    check("coinc rises", 16'(rises - r0), 16'd1);

    // Shrink period 0x0100 -> 0x0010 with cnt at 0x80
    do_write(4'd11, 8'h00, 1'b0);
    do_write(4'd12, 8'h01, 1'b0);
    do_write(4'd13, 8'h0E, 1'b0);
    cens(128, 1);
    check("shrink pre step", {15'd0, step}, 16'd0);
    do_write(4'd12, 8'h00, 1'b0);
    do_write(4'd11, 8'h10, 1'b0);
    check("shrink period", period, 16'h0010);
    cens(1, 1);
    check("shrink immediate", {15'd0, step}, 16'd1);
    r0 = rises;
    cens(32, 2);
    check("shrink rises", 16'(rises - r0), YM ? 16'd2 : 16'd1);

    // Period 0
    do_write(4'd11, 8'h00, 1'b0);
    check("p0 period", period, 16'h0000);
    check("p0 null lag", {15'd0, null_period}, 16'd0);
    @(negedge clk);
    check("p0 null", {15'd0, null_period}, 16'd1);
    r0 = rises;
    cens(5, 2);
    check("p0 no rises", 16'(rises - r0), 16'd0);
    do_write(4'd11, 8'h01, 1'b0);
    @(negedge clk);
    check("p1 null clr", {15'd0, null_period}, 16'd0);
    r0 = rises;
    cens(4, 2);
    check("p1 rises", 16'(rises - r0), YM ? 16'd1 : 16'd2);

    // Reset mid-count
    do_write(4'd11, 8'd3, 1'b0);
    cens(2, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst period", period, 16'h0000);
    check("mid rst ctrl", {12'd0, ctrl}, 16'h0000);
    check("mid rst step", {15'd0, step}, 16'h0000);
    check("mid rst restart", {15'd0, restart}, 16'h0000);
    check("mid rst null", {15'd0, null_period}, 16'h0001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_write(4'd11, 8'd3, 1'b0);
    cens(2, 4);
    check("after rst step 2", {15'd0, step}, 16'd0);
    cens(1, 4);
    check("after rst step 3", {15'd0, step}, 16'd1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
